// File: rtl/arb_req_pkg.sv
// Shared types and default configuration for the arbiter requester slice.
package arb_req_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    OWN
  } state_t;

  localparam int DW_DEF      = 8;
  localparam int DEPTH_DEF   = 4;
  localparam int TIMEOUT_DEF = 15;

endpackage

// File: rtl/arb_req_fifo.sv
// Circular FIFO with occupancy count; caller guarantees no push when full, no pop when empty.
module arb_req_fifo
  import arb_req_pkg::*;
#(
  parameter int DW    = DW_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [DW-1:0]              wdata,
  output logic [DW-1:0]              rdata,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  logic [DW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  assign rdata = mem[rd_ptr];

  // Power-of-two depth lets the pointers wrap by natural overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      level <= level + LW'(push) - LW'(pop);
    end
  end

endmodule

// File: rtl/arb_requester.sv
// Buffers upstream words and requests an arbiter slot to drain them.
// Optional starvation pulse enabled by defining ARB_REQ_STARVE_EN.
module arb_requester
  import arb_req_pkg::*;
#(
  parameter int DW      = DW_DEF,
  parameter int DEPTH   = DEPTH_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic [DW-1:0]          in_data,
  output logic                   in_ready,
  output logic                   req,
  input  logic                   gnt,
  output logic                   out_valid,
  output logic [DW-1:0]          out_data,
  output logic [$clog2(DEPTH):0] level,
  output logic                   starve
);

  localparam int LW = $clog2(DEPTH) + 1;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("arb_requester: DEPTH must be a power of two >= 2");
  end
  if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
    $error("arb_requester: TIMEOUT must be in 1..255");
  end

  state_t        state, state_next;
  logic          push, pop;
  logic [LW-1:0] lvl_next;
  logic [DW-1:0] head;

  assign in_ready = (level != LW'(DEPTH));
  assign push     = in_valid && in_ready;
  assign pop      = (state == OWN) && gnt && (level != '0);
  assign lvl_next = level + LW'(push) - LW'(pop);
  assign req      = (state != IDLE);

  arb_req_fifo #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata (in_data),
    .rdata (head),
    .level (level)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: if (lvl_next != '0) state_next = WAIT;
      WAIT: if (gnt) state_next = OWN;
      OWN: begin
        if (gnt) begin
          if (lvl_next == '0) state_next = IDLE;
        end else begin
          state_next = (level != '0) ? WAIT : IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      out_valid <= pop;
      if (pop) out_data <= head;
    end
  end

`ifdef ARB_REQ_STARVE_EN
  logic [7:0] starve_cnt;
  logic [7:0] starve_inc;

  assign starve_inc = starve_cnt + 8'd1;

  // Counter restarts on every WAIT entry; a pulse clears it and counting resumes.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= '0;
      starve     <= 1'b0;
    end else begin
      starve <= 1'b0;
      if (state != WAIT && state_next == WAIT) begin
        starve_cnt <= '0;
      end else if (state == WAIT) begin
        if (starve_inc == 8'(TIMEOUT)) begin
          starve     <= 1'b1;
          starve_cnt <= '0;
        end else begin
          starve_cnt <= starve_inc;
        end
      end
    end
  end
`else
  assign starve = 1'b0;
`endif

endmodule

// File: tb/tb_arb_requester.sv
// Directed self-checking bench for arb_requester with hand-computed expectations.
module tb_arb_requester;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       req;
  logic       gnt;
  logic       out_valid;
  logic [7:0] out_data;
  logic [2:0] level;
  logic       starve;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  arb_requester #(
    .DW      (8),
    .DEPTH   (4),
    .TIMEOUT (15)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .req       (req),
    .gnt       (gnt),
    .out_valid (out_valid),
    .out_data  (out_data),
    .level     (level),
    .starve    (starve)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Checks the three observable status signals after a clock edge.
  task automatic status(input string tag, input logic e_req, input logic [2:0] e_lvl,
                        input logic e_ov);
    check({tag, ".req"}, 32'(req), 32'(e_req));
    check({tag, ".level"}, 32'(level), 32'(e_lvl));
    check({tag, ".out_valid"}, 32'(out_valid), 32'(e_ov));
  endtask

  logic e_starve;

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; gnt = 1'b0;
    step();
    step();
    status("reset", 1'b0, 3'd0, 1'b0);
    check("reset.out_data", 32'(out_data), 32'h00);
    check("reset.starve", 32'(starve), 32'h0);
    check("reset.in_ready", 32'(in_ready), 32'h1);
    rst = 1'b0;

    // Two pushes, no grant
    in_valid = 1'b1; in_data = 8'hA1; step();
    status("t1.push1", 1'b1, 3'd1, 1'b0);
    in_data = 8'hA2; step();
    status("t1.push2", 1'b1, 3'd2, 1'b0);
    in_valid = 1'b0;
    // First grant cycle moves WAIT->OWN, next two pop
    gnt = 1'b1; step();
    status("t1.own", 1'b1, 3'd2, 1'b0);
    step();
    status("t1.pop1", 1'b1, 3'd1, 1'b1);
    check("t1.data1", 32'(out_data), 32'hA1);
    step();
    status("t1.pop2", 1'b0, 3'd0, 1'b1);
    check("t1.data2", 32'(out_data), 32'hA2);
    gnt = 1'b0; step();
    status("t1.after", 1'b0, 3'd0, 1'b0);
    check("t1.hold", 32'(out_data), 32'hA2);

    // Fill to full, overflow word must be dropped
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_data = 8'hB1 + 8'(i);
      step();
      check("t2.fill_level", 32'(level), 32'(i + 1));
    end
    check("t2.in_ready_full", 32'(in_ready), 32'h0);
    in_data = 8'hFF; step();
    check("t2.no_overflow", 32'(level), 32'd4);
    in_valid = 1'b0;
    gnt = 1'b1; step();
    status("t2.own", 1'b1, 3'd4, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step();
      check("t2.drain_valid", 32'(out_valid), 32'h1);
      check("t2.drain_data", 32'(out_data), 32'(8'hB1 + 8'(i)));
    end
    check("t2.end_req", 32'(req), 32'h0);
    gnt = 1'b0; step();
    check("t2.no_ff", 32'(out_valid), 32'h0);

    // Push during pop keeps the level constant
    in_valid = 1'b1; in_data = 8'hC1; step();
    in_data = 8'hC2; step();
    in_valid = 1'b0; gnt = 1'b1; step();
    status("t3.own", 1'b1, 3'd2, 1'b0);
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_data = 8'hC3 + 8'(i);
      step();
      status("t3.steady", 1'b1, 3'd2, 1'b1);
      check("t3.order", 32'(out_data), 32'(8'hC1 + 8'(i)));
    end
    in_valid = 1'b0;
    step();
    check("t3.tail1", 32'(out_data), 32'hC4);
    step();
    status("t3.tail2", 1'b0, 3'd0, 1'b1);
    check("t3.tail2_data", 32'(out_data), 32'hC5);

    // Grant while idle and empty is ignored
    step();
    status("t4.idle_gnt", 1'b0, 3'd0, 1'b0);
    gnt = 1'b0;

    // Starvation: WAIT entered on the push edge, pulse 15 cycles later
    in_valid = 1'b1; in_data = 8'hD1; step();
    in_valid = 1'b0;
    check("t5.wait_req", 32'(req), 32'h1);
    for (int i = 1; i <= 17; i++) begin
      step();
`ifdef ARB_REQ_STARVE_EN
      e_starve = (i == 15);
`else
      e_starve = 1'b0;
`endif
      check($sformatf("t5.starve_c%0d", i), 32'(starve), 32'(e_starve));
    end

    // Reset in the middle of a transfer
    in_valid = 1'b1; in_data = 8'hE2; step();
    in_data = 8'hE3; step();
    in_valid = 1'b0; gnt = 1'b1; step();
    status("t6.own", 1'b1, 3'd3, 1'b0);
    rst = 1'b1; step();
    status("t6.rst", 1'b0, 3'd0, 1'b0);
    check("t6.rst_data", 32'(out_data), 32'h00);
    rst = 1'b0; step();
    status("t6.release", 1'b0, 3'd0, 1'b0);
    step();
    status("t6.stale", 1'b0, 3'd0, 1'b0);
    gnt = 1'b0; step();
    check("t6.starve", 32'(starve), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
